alu_iter: RTL
=============

Name: alu_iter

Overview:
- Parametrised execute-stage ALU, the successor to the single-cycle combinational ALU.
- Adds a registered result and a valid/ready handshake on both sides.
- Completes the RV32I base operations in 1 cycle, including the SUB, SRA and signed/unsigned SLT/SLTU distinctions the old block lacked.
- Adds an iterative multi-cycle unit for MUL, MULHU, DIVU and REMU.
- Sits between decode/register-read and writeback; the pipeline stalls on IN_READY low.

Parameters:
- XLEN, 32, datapath width; legal values 8..64.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  reset; asynchronous, active-high
- IN_VALID  input  1  operands and OP are presented
- IN_READY  output  1  block can accept an operation this cycle
- A  input  XLEN  operand 1 (rs1)
- B  input  XLEN  operand 2 (rs2 or immediate)
- OP  input  5  OP[4]=M-ext select, OP[3]=alt (funct7[5]), OP[2:0]=funct3
- OUT_VALID  output  1  OUT holds a result
- OUT_READY  input  1  consumer takes the result
- OUT  output  XLEN  result
- BUSY  output  1  iterative unit is running

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; OUT=0; OUT_VALID=0; BUSY=0; iteration counter=0.
  - IN_READY goes high in IDLE.
  - An operation in flight is discarded and produces no result.
- Accept: an operation is accepted on a rising edge with IN_VALID&IN_READY. A, B and OP are captured; they need not stay stable afterwards.
- States: IDLE, BUSY, DONE.
  - IN_READY = (state==IDLE) | (state==DONE & OUT_READY). This gives back-to-back issue with zero bubble.
  - OUT_VALID = (state==DONE).
  - BUSY = (state==BUSY).
- Base operations, OP[4]=0:
  - 000: ADD; with alt=1, SUB. Modulo 2^XLEN.
  - 001: SLL by B[SHAMT_W-1:0].
  - 010: SLT, signed compare, result 1 or 0.
  - 011: SLTU, unsigned compare, result 1 or 0.
  - 100: XOR.
  - 101: SRL; with alt=1, SRA (sign-filling). Shift by B[SHAMT_W-1:0].
  - 110: OR.
  - 111: AND.
  - Alt is ignored except for funct3 000 and 101.
  - Accept -> DONE next edge, OUT=result. Latency 1.
- M-ext operations, OP[4]=1, alt ignored:
  - 000: MUL, low XLEN bits of the product.
  - 011: MULHU, high XLEN bits of the unsigned product.
  - 101: DIVU.
  - 111: REMU.
  - Any other funct3: OUT=0, latency 1.
- MUL/MULHU:
  - Shift-add over a 2*XLEN accumulator, one multiplier bit per cycle.
  - Accept -> BUSY for XLEN cycles -> DONE. OUT_VALID rises XLEN+1 edges after accept.
- DIVU/REMU:
  - Restoring division, one quotient bit per cycle, same XLEN+1 latency.
  - B==0 shortcut: DONE after 1 edge. DIVU gives all-ones; REMU gives A. No BUSY cycles.
- Output hold: while OUT_VALID & !OUT_READY, OUT and state are frozen and IN_READY=0.
- Release: on an edge with OUT_VALID & OUT_READY:
  - If IN_VALID is also high, the new operation is accepted on that same edge: DONE->DONE for a base op, DONE->BUSY for an iterative op.
  - Otherwise the block returns to IDLE. OUT keeps its last value; it is don't-care when OUT_VALID=0.
- While BUSY, IN_VALID is ignored; IN_READY=0.
- Counter width is ceil(log2(XLEN+1)); it terminates at exactly XLEN iterations.

Test Plan:
- Reset mid-MUL: assert RST on the 10th BUSY cycle -> OUT_VALID=0, BUSY=0, IN_READY=1 immediately; no result is ever emitted.
- Base ops, back-to-back with OUT_READY=1:
  - ADD 5+7 -> 12.
  - SUB 3-5 -> 0xFFFFFFFE.
  - SRA 0x80000000>>4 -> 0xF8000000.
  - SRL same operands -> 0x08000000.
  - SLT(-1,1) -> 1; SLTU(0xFFFFFFFF,1) -> 0.
  - One result per cycle, no bubbles.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> MUL=0x00000001, MULHU=0xFFFFFFFE. OUT_VALID exactly 33 edges after accept; BUSY high for 32 cycles.
- DIVU 100/7 -> 14; REMU -> 2, latency 33. DIVU x/0 -> 0xFFFFFFFF and REMU 9/0 -> 9, each at latency 1.
- Backpressure: hold OUT_READY=0 for 5 cycles after DONE -> OUT stable, IN_READY=0. Release together with a new IN_VALID -> accepted on that same edge.
- XLEN=16, SHAMT_W=4 build: MULHU 0xFFFF*0x0002 -> 0x0001; OUT_VALID after 17 edges.

Source files
------------

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle RV32I base operations plus an iterative
// shift-add multiplier / restoring divider, with valid/ready on both sides.
module alu_iter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      OP,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] OUT,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t              state_q, state_d;
    logic [XLEN-1:0]     out_q, out_d;
    logic [XLEN-1:0]     dvsr_q, dvsr_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          mop_q, mop_d;

    logic [XLEN-1:0]     base_res;
    logic [XLEN-1:0]     imm_res;
    logic                is_iter_op;
    logic                div_by_zero;
    logic                start_iter;
    logic                accept;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   step_acc;
    logic [XLEN-1:0]     step_res;

    assign IN_READY  = (state_q == S_IDLE) | ((state_q == S_DONE) & OUT_READY);
    assign OUT_VALID = (state_q == S_DONE);
    assign BUSY      = (state_q == S_BUSY);
    assign OUT       = out_q;
    assign accept    = IN_VALID & IN_READY;

    always_comb begin
        base_res = '0;
        case (OP[2:0])
            3'b000: base_res = OP[3] ? (A - B) : (A + B);
            3'b001: base_res = A << B[SHAMT_W-1:0];
            3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            3'b011: base_res = {{(XLEN-1){1'b0}}, (A < B)};
            3'b100: base_res = A ^ B;
            3'b101: base_res = OP[3] ? $unsigned($signed(A) >>> B[SHAMT_W-1:0])
                                     : (A >> B[SHAMT_W-1:0]);
            3'b110: base_res = A | B;
            default: base_res = A & B;
        endcase
    end

    // MUL/MULHU/DIVU/REMU run iteratively; a zero divisor short-circuits.
    assign is_iter_op  = OP[4] & ((OP[2:0] == 3'b000) | (OP[2:0] == 3'b011) |
                                  (OP[2:0] == 3'b101) | (OP[2:0] == 3'b111));
    assign div_by_zero = OP[2] & (B == '0);
    assign start_iter  = is_iter_op & ~div_by_zero;

    always_comb begin
        imm_res = '0;
        if (!OP[4]) begin
            imm_res = base_res;
        end else if (is_iter_op && div_by_zero) begin
            imm_res = OP[1] ? A : '1;
        end
    end

    // acc = {high, low}: multiply keeps {partial product, multiplier},
    // divide keeps {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvsr_q};
    assign div_ge    = ~div_diff[XLEN];
    assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
    assign step_acc  = mop_q[1] ? div_next : mul_next;
    assign step_res  = mop_q[0] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        acc_d   = acc_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        mop_d   = mop_q;
        case (state_q)
            S_BUSY: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    out_d   = step_res;
                end
            end
            default: begin
                if (accept) begin
                    if (start_iter) begin
                        state_d = S_BUSY;
                        acc_d   = {{XLEN{1'b0}}, A};
                        dvsr_d  = B;
                        cnt_d   = '0;
                        mop_d   = OP[2:1];
                    end else begin
                        state_d = S_DONE;
                        out_d   = imm_res;
                    end
                end else if ((state_q == S_DONE) && OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            acc_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            mop_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            mop_q   <= mop_d;
        end
    end

endmodule
